// File: rtl/regfile_param.sv
// Parametrised multi-port register file: byte-lane writes, optional bypass,
// optional registered reads, optional hardwired-zero entry 0, sequential clear engine.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     aw,
  input  logic [DATA_W-1:0]     dw,
  input  logic                  wr_en,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [ADDR_W-1:0]     aa,
  input  logic [ADDR_W-1:0]     ab,
  output logic [DATA_W-1:0]     da,
  output logic [DATA_W-1:0]     db,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  wr_drop,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_eff;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;

  always_comb begin
    wr_eff = wr_en && (state == IDLE) && !((ZERO_REG != 0) && (aw == '0));
  end

  always_comb begin
    merged = mem[aw];
    for (int unsigned i = 0; i < NB; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = dw[8*i +: 8];
    end
  end

  // Zero-register override takes priority over the bypass path.
  always_comb begin
    ra = mem[aa];
    if ((BYPASS != 0) && wr_eff && (aa == aw)) ra = merged;
    if ((ZERO_REG != 0) && (aa == '0)) ra = '0;
  end

  always_comb begin
    rb = mem[ab];
    if ((BYPASS != 0) && wr_eff && (ab == aw)) rb = merged;
    if ((ZERO_REG != 0) && (ab == '0)) rb = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      state   <= IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && (state == CLEAR);
      if (state == CLEAR) begin
        mem[cnt] <= '0;
        cnt      <= cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state <= IDLE;
      end else begin
        if (wr_eff) mem[aw] <= merged;
        if (clr_req) begin
          state <= CLEAR;
          cnt   <= '0;
        end
      end
    end
  end

  assign clr_busy = (state == CLEAR);
  assign dbg_data = mem[dbg_addr];

  generate
    if (READ_REG != 0) begin : g_rreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          da <= '0;
          db <= '0;
        end else begin
          da <= ra;
          db <= rb;
        end
      end
    end else begin : g_comb
      assign da = ra;
      assign db = rb;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: two configurations driven in lockstep and
// compared against an array-based reference model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  aw, aa, ab, dbg_addr;
  logic [31:0] dw;
  logic        wr_en, clr_req;
  logic [3:0]  byte_en;

  logic [31:0] da0, db0, dbg0, da1, db1, dbg1;
  logic        busy0, drop0, busy1, drop1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Config 0: defaults (zero reg, bypass, combinational reads).
  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .aw(aw), .dw(dw), .wr_en(wr_en), .byte_en(byte_en),
    .aa(aa), .ab(ab), .da(da0), .db(db0), .clr_req(clr_req), .clr_busy(busy0),
    .wr_drop(drop0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  // Config 1: no zero reg, no bypass, registered reads.
  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .READ_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .aw(aw), .dw(dw), .wr_en(wr_en), .byte_en(byte_en),
    .aa(aa), .ab(ab), .da(da1), .db(db1), .clr_req(clr_req), .clr_busy(busy1),
    .wr_drop(drop1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  // Reference model state
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  bit          busy_m;
  int          cnt_m;
  bit          drop_m;
  logic [31:0] q1a, q1b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  function automatic logic [31:0] r0(input logic [4:0] x);
    if (x == 5'd0) return 32'h0;
    if (wr_en && !busy_m && aw != 5'd0 && x == aw) return merge(m0[x], dw, byte_en);
    return m0[x];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    busy_m = 0; cnt_m = 0; drop_m = 0; q1a = '0; q1b = '0;
  endtask

  task automatic model_edge();
    bit e0, e1;
    e0 = wr_en && !busy_m && aw != 5'd0;
    e1 = wr_en && !busy_m;
    q1a = m1[aa];
    q1b = m1[ab];
    drop_m = wr_en && busy_m;
    if (busy_m) begin
      m0[cnt_m] = '0;
      m1[cnt_m] = '0;
      cnt_m++;
      if (cnt_m == 32) busy_m = 0;
    end else begin
      if (e0) m0[aw] = merge(m0[aw], dw, byte_en);
      if (e1) m1[aw] = merge(m1[aw], dw, byte_en);
      if (clr_req) begin
        busy_m = 1;
        cnt_m  = 0;
      end
    end
  endtask

  task automatic cyc(input bit w, input logic [4:0] a_w, input logic [31:0] d_w,
                     input logic [3:0] be, input logic [4:0] a_a, input logic [4:0] a_b,
                     input bit clr, input logic [4:0] dbg);
    @(negedge clk);
    wr_en = w; aw = a_w; dw = d_w; byte_en = be; aa = a_a; ab = a_b;
    clr_req = clr; dbg_addr = dbg;
    #1;
    check("da0",   da0,   r0(aa));
    check("db0",   db0,   r0(ab));
    check("dbg0",  dbg0,  m0[dbg]);
    check("busy0", {31'b0, busy0}, {31'b0, busy_m});
    check("drop0", {31'b0, drop0}, {31'b0, drop_m});
    check("da1",   da1,   q1a);
    check("db1",   db1,   q1b);
    check("dbg1",  dbg1,  m1[dbg]);
    check("busy1", {31'b0, busy1}, {31'b0, busy_m});
    check("drop1", {31'b0, drop1}, {31'b0, drop_m});
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic [4:0] a_a, input logic [4:0] a_b, input logic [4:0] dbg);
    cyc(0, 5'd0, 32'h0, 4'h0, a_a, a_b, 0, dbg);
  endtask

  // Asynchronous reset asserted mid-cycle; storage must read zero immediately.
  task automatic do_reset();
    #2;
    wr_en = 0; clr_req = 0;
    rst_n = 1'b0;
    #1;
    check("rst_busy0", {31'b0, busy0}, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_drop1", {31'b0, drop1}, 32'h0);
    check("rst_da1", da1, 32'h0);
    check("rst_db1", db1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      check("rst_dbg0", dbg0, 32'h0);
      check("rst_dbg1", dbg1, 32'h0);
    end
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; clr_req = 0; aw = '0; dw = '0; byte_en = '0; aa = '0; ab = '0; dbg_addr = '0;
    model_reset();
    #12 rst_n = 1'b1;

    idle(5'd2, 5'd3, 5'd2);

    // Basic write then a non-enabled write
    cyc(1, 5'd2, 32'h0000_002A, 4'hF, 5'd2, 5'd2, 0, 5'd2);
    cyc(0, 5'd2, 32'h0000_000F, 4'hF, 5'd2, 5'd2, 0, 5'd2);
    check("basic_da0", da0, 32'h0000_002A);
    idle(5'd2, 5'd2, 5'd2);
    check("basic_da1", da1, 32'h0000_002A);

    // Byte lanes with bypass
    cyc(1, 5'd5, 32'h1122_3344, 4'hF, 5'd1, 5'd1, 0, 5'd5);
    cyc(1, 5'd5, 32'hAABB_CCDD, 4'b0101, 5'd5, 5'd5, 0, 5'd5);
    #1 check("lane_bypass", da0, 32'h11BB_33DD);
    idle(5'd5, 5'd5, 5'd5);
    check("lane_store", dbg0, 32'h11BB_33DD);

    // Zero register and decoder isolation
    cyc(1, 5'd0, 32'd12, 4'hF, 5'd0, 5'd0, 0, 5'd0);
    cyc(1, 5'd17, 32'd29, 4'hF, 5'd0, 5'd0, 0, 5'd0);
    cyc(1, 5'd2, 32'd55, 4'hF, 5'd2, 5'd17, 0, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'd2, 5'd17, 5'(i));
    check("zero_da0", da0, 32'd55);
    check("zero_db0", db0, 32'd29);

    // Fill every entry, then clear with a write and a clr_req during busy
    for (int i = 0; i < 32; i++)
      cyc(1, 5'(i), $urandom | 32'h1, 4'hF, 5'($urandom), 5'($urandom), 0, 5'(i));
    cyc(0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd4, 1, 5'd0);
    for (int i = 0; i < 34; i++) begin
      if (i == 10) cyc(1, 5'd20, 32'hDEAD_BEEF, 4'hF, 5'd20, 5'd20, 0, 5'd20);
      else cyc(0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), (i == 15), 5'(i));
    end
    check("clr_done", {31'b0, busy0}, 32'h0);

    // Reset during clear, then a normal write
    for (int i = 0; i < 32; i++) cyc(1, 5'(i), 32'h0000_0100 + i, 4'hF, 5'd0, 5'd0, 0, 5'(i));
    cyc(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1, 5'd0);
    for (int i = 0; i < 7; i++) idle(5'd9, 5'd30, 5'(i));
    do_reset();
    cyc(1, 5'd4, 32'h0000_0099, 4'hF, 5'd4, 5'd4, 0, 5'd4);
    idle(5'd4, 5'd4, 5'd4);
    check("post_rst_rd", da0, 32'h0000_0099);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a;
      a = 5'($urandom);
      if (n == 700) do_reset();
      cyc(($urandom % 3) != 0, a, $urandom, 4'($urandom),
          ($urandom % 2) ? a : 5'($urandom), ($urandom % 2) ? a : 5'($urandom),
          ($urandom % 80) == 0, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
